// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for pulse_period_meter: FSM state encodings and the
// all-ones saturation value for a W-bit period counter.
package pulse_period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Largest value a w-bit counter can hold before it would wrap.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Falling-edge sampler for the tick stream; keeps the previous sample
// internally and flags a 0->1 transition combinationally.
module pulse_period_meter_rise_detect (
  input  logic clk,
  input  logic clear,
  input  logic pulse_in,
  output logic rise
);

  logic prev_reg;

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) prev_reg <= 1'b0;
    else        prev_reg <= pulse_in;
  end

  assign rise = pulse_in & ~prev_reg;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures falling-edge clock counts between rises of pulse_in and checks them
// against N. Build option PERIOD_METER_LOCK_EN adds the N comparison and lock.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int N        = 5,
  parameter int W        = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         pulse_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         error
);

  localparam logic [W-1:0] CNT_MAX = W'(sat_max(W));

  state_t       state_reg, state_next;
  logic [W-1:0] count_reg, count_next;
  logic [W-1:0] period_next;
  logic         rise;
  logic         valid_next;
  logic         error_next;
  logic         measured;
  logic         overflow;

  pulse_period_meter_rise_detect u_rise_detect (
    .clk      (clk),
    .clear    (clear),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: if (!rise && count_reg == CNT_MAX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rise on the saturating edge is a measurement, not an overflow.
  always_comb begin
    count_next  = count_reg;
    period_next = period;
    valid_next  = 1'b0;
    measured    = 1'b0;
    overflow    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) count_next = W'(1);
      end
      MEASURE: begin
        if (rise) begin
          period_next = count_reg;
          valid_next  = 1'b1;
          measured    = 1'b1;
          count_next  = W'(1);
        end else if (count_reg == CNT_MAX) begin
          overflow   = 1'b1;
          count_next = '0;
        end else begin
          count_next = count_reg + W'(1);
        end
      end
      default: count_next = '0;
    endcase
  end

`ifdef PERIOD_METER_LOCK_EN
  localparam int            MW       = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  N_VAL    = W'(N);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

  logic [MW-1:0] match_reg, match_next;
  logic          mismatch;

  always_comb begin
    match_next = match_reg;
    mismatch   = measured && (count_reg != N_VAL);
    if (overflow || mismatch)
      match_next = '0;
    else if (measured && match_reg != LOCK_MAX)
      match_next = match_reg + MW'(1);
  end

  // locked follows the updated match count so it moves on the measuring edge.
  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      match_reg <= '0;
      locked    <= 1'b0;
    end else begin
      match_reg <= match_next;
      locked    <= (match_next == LOCK_MAX);
    end
  end

  assign error_next = overflow | mismatch;
`else
  assign locked     = 1'b0;
  assign error_next = overflow;
`endif

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      count_reg    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      count_reg    <= count_next;
      period       <= period_next;
      period_valid <= valid_next;
      error        <= error_next;
    end
  end

endmodule
